// File: rtl/alu_sequencer.sv
// Program-driven ALU initiator: issues one stored word at a time, waits ALU_LAT cycles,
// then writes alu_result back into a 4-entry register file.
module alu_sequencer #(
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [M+5:0]  prog_wdata,
    input  logic          reg_we,
    input  logic [1:0]    reg_addr,
    input  logic [N-1:0]  reg_wdata,
    input  logic [1:0]    rd_addr,
    output logic [N-1:0]  rd_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [M-1:0]  alu_instr,
    input  logic [N-1:0]  alu_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [AW:0]  pc_q, pc_d, len_q, len_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [1:0]   dst_q, dst_d;
    logic [N-1:0] a_q, a_d, b_q, b_d;
    logic [M-1:0] instr_q, instr_d;
    logic [M+5:0] mem_q [DEPTH];
    logic [N-1:0] regs_q [4];
    logic [M+5:0] word;
    logic [AW:0]  pc_inc;
    logic         wb_en;

    assign rd_data   = regs_q[rd_addr];
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_instr = instr_q;
    assign word      = mem_q[pc_q[AW-1:0]];
    assign pc_inc    = pc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        instr_d = instr_q;
        wb_en   = 1'b0;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    state_d = (prog_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Operands are captured here, so a word whose dst aliases a source reads the old value.
                a_d     = regs_q[word[3:2]];
                b_d     = regs_q[word[1:0]];
                instr_d = word[M+5:6];
                dst_d   = word[5:4];
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'(ALU_LAT)) begin
                    wb_en   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = (pc_inc == len_q) ? DONE : ISSUE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            instr_q <= instr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (prog_we && !busy) begin
            mem_q[prog_addr] <= prog_wdata;
        end
    end

    // Writeback owns the register write port while busy; host writes only land in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[dst_q] <= alu_result;
        end else if (reg_we && !busy) begin
            regs_q[reg_addr] <= reg_wdata;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a one-cycle registered adder standing in for the ALU.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [9:0] prog_wdata;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [3:0] reg_wdata;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       start;
    logic [3:0] prog_len;
    logic       busy, done;
    logic [3:0] alu_a, alu_b, alu_instr;
    logic [3:0] alu_result;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] instr;
    } iss_t;

    iss_t       iss_q[$];
    logic [3:0] mreg [4];
    logic [9:0] mprog [8];

    alu_sequencer #(.N(4), .M(4), .DEPTH(8), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .start(start), .prog_len(prog_len),
        .busy(busy), .done(done),
        .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) alu_result <= alu_a + alu_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic [3:0] op, input logic [1:0] d,
                                      input logic [1:0] sa, input logic [1:0] sb);
        return {op, d, sa, sb};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        for (int i = 0; i < 8; i++) mprog[i] = '0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
        mreg[a] = d;
    endtask

    task automatic wr_prog(input logic [2:0] a, input logic [9:0] w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = w;
        @(negedge clk);
        prog_we = 1'b0;
        mprog[a] = w;
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("%s_R%0d", tag, a), {28'b0, rd_data}, {28'b0, mreg[a]});
        end
    endtask

    task automatic run(input int len, input bit lockout, input string tag);
        int exp_done = len * 3 + 1;
        int done_at  = -1;
        int done_cnt = 0;
        int wi       = 0;
        iss_t got, exp;
        for (int i = 0; i < len; i++) begin
            logic [9:0] w;
            logic [3:0] s;
            w = mprog[i];
            iss_q.push_back({mreg[w[3:2]], mreg[w[1:0]], w[9:6]});
            s = mreg[w[3:2]] + mreg[w[1:0]];
            mreg[w[5:4]] = s;
        end
        @(negedge clk);
        start = 1'b1; prog_len = 4'(len);
        @(posedge clk);
        for (int c = 1; c <= exp_done + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                chk({tag, "_busy_c1"}, {31'b0, busy}, 32'd1);
            end
            if (lockout) begin
                start = (c == 3);
                if (c <= 8) begin
                    prog_we = 1'b1; prog_addr = 3'(c - 1); prog_wdata = 10'h3FF;
                    reg_we  = 1'b1; reg_addr  = 2'(c - 1); reg_wdata  = 4'hF;
                end else begin
                    prog_we = 1'b0; reg_we = 1'b0;
                end
            end
            if (c >= 2 && (c - 2) % 3 == 0 && wi < len) begin
                got = {alu_a, alu_b, alu_instr};
                exp = (iss_q.size() > 0) ? iss_q.pop_front() : '0;
                chk($sformatf("%s_issue%0d", tag, wi), {20'b0, got}, {20'b0, exp});
                wi++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == exp_done + 1) chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        end
        chk({tag, "_done_cycle"}, done_at, exp_done);
        chk({tag, "_done_width"}, done_cnt, 1);
        chk({tag, "_sb_left"}, iss_q.size(), 0);
        iss_q.delete();
        check_regs(tag);
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; prog_len = '0; rd_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_alu", {20'b0, alu_a, alu_b, alu_instr}, 32'd0);
        check_regs("rst");

        // Mid-program reset during WAIT of a 3-word run
        wr_reg(2'd1, 4'd1);
        wr_reg(2'd2, 4'd2);
        wr_prog(3'd0, mk(4'h1, 2'd0, 2'd1, 2'd2));
        wr_prog(3'd1, mk(4'h2, 2'd3, 2'd0, 2'd0));
        wr_prog(3'd2, mk(4'h3, 2'd1, 2'd3, 2'd1));
        @(negedge clk);
        start = 1'b1; prog_len = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst_pre_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_alu", {20'b0, alu_a, alu_b, alu_instr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_regs("midrst");
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        // Program memory was cleared: word 0 is op 0, R0 = R0 + R0
        run(1, 1'b0, "cleared");

        wr_reg(2'd1, 4'd3);
        wr_reg(2'd2, 4'd5);
        wr_prog(3'd0, mk(4'hA, 2'd0, 2'd1, 2'd2));
        run(1, 1'b0, "single");
        chk("single_R0_const", {28'b0, mreg[0]}, 32'd8);

        wr_reg(2'd1, 4'd1);
        wr_reg(2'd2, 4'd2);
        wr_prog(3'd0, mk(4'h1, 2'd0, 2'd1, 2'd2));
        wr_prog(3'd1, mk(4'h2, 2'd3, 2'd0, 2'd0));
        wr_prog(3'd2, mk(4'h3, 2'd1, 2'd3, 2'd1));
        run(3, 1'b0, "chain");

        wr_reg(2'd1, 4'd1);
        wr_reg(2'd2, 4'd2);
        run(3, 1'b1, "lockout");
        wr_reg(2'd1, 4'd1);
        wr_reg(2'd2, 4'd2);
        run(3, 1'b0, "rerun");

        run(0, 1'b0, "zero");

        wr_reg(2'd0, 4'd0);
        wr_reg(2'd1, 4'd2);
        for (int i = 0; i < 8; i++) wr_prog(3'(i), mk(4'h5, 2'd0, 2'd0, 2'd1));
        run(8, 1'b0, "full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
